// File: rtl/edge_det_multi.sv
// Multi-channel edge detector: synchroniser, glitch filter, qualified
// edge strobes, sticky pending flags and saturating event counters.
module edge_det_multi #(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT        = 3,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH-1:0]         sig_in,
   input  logic [2*CH-1:0]       mode,
   input  logic [CH-1:0]         clr,
   output logic [CH-1:0]         level,
   output logic [CH-1:0]         rise,
   output logic [CH-1:0]         fall,
   output logic [CH-1:0]         pulse,
   output logic [CH-1:0]         pending,
   output logic [CH*CNT_W-1:0]   count,
   output logic                  any_pending
);

   localparam int FW = $clog2(FILT + 1);
   localparam logic [FW-1:0] F_LAST = FW'(FILT - 1);
   localparam logic [CNT_W-1:0] C_MAX = '1;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [FW-1:0]          filt_q;
      logic [CNT_W-1:0]       cnt_q;
      logic                   lvl_q;
      logic                   rise_q;
      logic                   fall_q;
      logic                   pulse_q;
      logic                   pend_q;
      logic                   sync;
      logic                   tgl;
      logic                   qual;

      assign sync = sync_q[SYNC_STAGES-1];
      assign tgl  = (sync != lvl_q) && (filt_q == F_LAST);
      // on a toggle, sync is the new level: 1 is a rise, 0 a fall
      assign qual = tgl && (sync ? mode[2*i] : mode[2*i+1]);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_q  <= '0;
            filt_q  <= '0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};

            if (sync == lvl_q) begin
               filt_q <= '0;
            end else if (tgl) begin
               filt_q <= '0;
               lvl_q  <= sync;
            end else begin
               filt_q <= filt_q + 1'b1;
            end

            rise_q  <= tgl & sync;
            fall_q  <= tgl & ~sync;
            pulse_q <= qual;
            pend_q  <= qual | (pend_q & ~clr[i]);

            if (clr[i])
               cnt_q <= qual ? CNT_W'(1) : '0;
            else if (qual && cnt_q != C_MAX)
               cnt_q <= cnt_q + 1'b1;
         end
      end

      assign level[i]   = lvl_q;
      assign rise[i]    = rise_q;
      assign fall[i]    = fall_q;
      assign pulse[i]   = pulse_q;
      assign pending[i] = pend_q;
      assign count[CNT_W*i +: CNT_W] = cnt_q;
   end

   assign any_pending = |pending;

endmodule

// File: tb/tb_edge_det_multi.sv
// Directed bench for edge_det_multi: expectations are queued with the
// cycle they are due and checked against the DUT at that cycle.
module tb_edge_det_multi;

   localparam int CH   = 4;
   localparam int SS   = 2;
   localparam int FILT = 3;
   localparam int CW   = 2;

   localparam int F_LVL  = 0;
   localparam int F_RISE = 1;
   localparam int F_FALL = 2;
   localparam int F_PUL  = 3;
   localparam int F_PEND = 4;
   localparam int F_ANY  = 5;
   localparam int F_CNT  = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic [CH-1:0]     sig_in;
   logic [2*CH-1:0]   mode;
   logic [CH-1:0]     clr;
   logic [CH-1:0]     level;
   logic [CH-1:0]     rise;
   logic [CH-1:0]     fall;
   logic [CH-1:0]     pulse;
   logic [CH-1:0]     pending;
   logic [CH*CW-1:0]  count;
   logic              any_pending;

   edge_det_multi #(
      .CH(CH), .SYNC_STAGES(SS), .FILT(FILT), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .sig_in(sig_in), .mode(mode), .clr(clr),
      .level(level), .rise(rise), .fall(fall), .pulse(pulse),
      .pending(pending), .count(count), .any_pending(any_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          at;
      string       tag;
      int          f;
      logic [31:0] mask;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   t;
   int   r;

   function automatic logic [31:0] obs(int f);
      case (f)
         F_LVL:   return 32'(level);
         F_RISE:  return 32'(rise);
         F_FALL:  return 32'(fall);
         F_PUL:   return 32'(pulse);
         F_PEND:  return 32'(pending);
         F_ANY:   return 32'(any_pending);
         default: return 32'(count);
      endcase
   endfunction

   task automatic cmp(string tag, int f, logic [31:0] mask, logic [31:0] exp);
      logic [31:0] o;
      o = obs(f) & mask;
      n_chk++;
      assert (o === (exp & mask)) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, o, exp & mask);
      end
   endtask

   function automatic void pv(int at, string tag, int f,
                              logic [31:0] mask, logic [31:0] exp);
      exp_t e;
      e.at = at; e.tag = tag; e.f = f; e.mask = mask; e.exp = exp;
      sb.push_back(e);
   endfunction

   function automatic void pb(int at, string tag, int f, int ch, logic v);
      pv(at, tag, f, 32'(1) << ch, 32'(v) << ch);
   endfunction

   function automatic void pc(int at, string tag, int ch, int v);
      pv(at, tag, F_CNT, 32'(3) << (CW * ch), 32'(v) << (CW * ch));
   endfunction

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         cyc++;
         #1;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
               cmp(sb[i].tag, sb[i].f, sb[i].mask, sb[i].exp);
               sb.delete(i);
            end else if (sb[i].at < cyc) begin
               n_chk++;
               n_fail++;
               $error("FAIL %s: stale at %0d observed cycle %0d",
                      sb[i].tag, sb[i].at, cyc);
               sb.delete(i);
            end
         end
      end
   endtask

   initial begin
      rst    = 1'b0;
      sig_in = '0;
      mode   = 8'hFF;
      clr    = '0;
      #1 rst = 1'b1;
      #1;
      cmp("rst_lvl",  F_LVL,  'hF,  0);
      cmp("rst_rise", F_RISE, 'hF,  0);
      cmp("rst_fall", F_FALL, 'hF,  0);
      cmp("rst_pul",  F_PUL,  'hF,  0);
      cmp("rst_pend", F_PEND, 'hF,  0);
      cmp("rst_cnt",  F_CNT,  'hFF, 0);
      cmp("rst_any",  F_ANY,  1,    0);
      step(2);
      rst = 1'b0;

      for (int k = 1; k <= 20; k++) begin
         pv(cyc + k, "idle_lvl", F_LVL, 'hF,  0);
         pv(cyc + k, "idle_pul", F_PUL, 'hF,  0);
         pv(cyc + k, "idle_cnt", F_CNT, 'hFF, 0);
         pv(cyc + k, "idle_any", F_ANY, 1,    0);
      end
      step(20);

      // ch3 off, ch2 rise only, ch1/ch0 both
      mode = 8'h1F;

      t = cyc;
      sig_in[0] = 1'b1;
      pb(t + 4, "c0_early",    F_LVL,  0, 0);
      pb(t + 4, "c0_early_r",  F_RISE, 0, 0);
      pb(t + 5, "c0_lvl",      F_LVL,  0, 1);
      pb(t + 5, "c0_rise",     F_RISE, 0, 1);
      pb(t + 5, "c0_pul",      F_PUL,  0, 1);
      pb(t + 5, "c0_pend",     F_PEND, 0, 1);
      pc(t + 5, "c0_cnt",      0, 1);
      pv(t + 5, "c0_any",      F_ANY, 1, 1);
      pb(t + 6, "c0_rise_end", F_RISE, 0, 0);
      pb(t + 6, "c0_pul_end",  F_PUL,  0, 0);
      step(10);

      t = cyc;
      sig_in[0] = 1'b0;
      pb(t + 4, "c0_fall_early", F_FALL, 0, 0);
      pb(t + 5, "c0_fall",       F_FALL, 0, 1);
      pb(t + 5, "c0_fall_pul",   F_PUL,  0, 1);
      pb(t + 5, "c0_fall_norise", F_RISE, 0, 0);
      pb(t + 5, "c0_fall_lvl",   F_LVL,  0, 0);
      pc(t + 5, "c0_cnt2",       0, 2);
      pb(t + 6, "c0_fall_end",   F_FALL, 0, 0);
      step(8);

      t = cyc;
      sig_in[1] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         pb(t + k, "glitch_lvl",  F_LVL,  1, 0);
         pb(t + k, "glitch_rise", F_RISE, 1, 0);
      end
      step(2);
      sig_in[1] = 1'b0;
      step(8);

      t = cyc;
      sig_in[1] = 1'b1;
      pb(t + 4, "min_early", F_RISE, 1, 0);
      pb(t + 5, "min_rise",  F_RISE, 1, 1);
      pb(t + 5, "min_lvl",   F_LVL,  1, 1);
      pb(t + 7, "min_hold",  F_LVL,  1, 1);
      pb(t + 7, "min_nofall", F_FALL, 1, 0);
      pb(t + 8, "min_fall",  F_FALL, 1, 1);
      pb(t + 8, "min_lvl0",  F_LVL,  1, 0);
      pc(t + 9, "min_cnt",   1, 2);
      step(3);
      sig_in[1] = 1'b0;
      step(8);

      t = cyc;
      sig_in[3:2] = 2'b11;
      pv(t + 5, "mode_rise", F_RISE, 'hC, 'hC);
      pv(t + 5, "mode_pul_r", F_PUL, 'hC, 'h4);
      step(6);
      t = cyc;
      sig_in[3:2] = 2'b00;
      pv(t + 5, "mode_fall",   F_FALL, 'hC, 'hC);
      pv(t + 5, "mode_pul_f",  F_PUL,  'hC, 'h0);
      pv(t + 5, "mode_norise", F_RISE, 'hC, 'h0);
      pc(t + 6, "mode_cnt2", 2, 1);
      pc(t + 6, "mode_cnt3", 3, 0);
      pv(t + 6, "mode_pend", F_PEND, 'hC, 'h4);
      step(8);

      for (int k = 0; k < 4; k++) begin
         t = cyc;
         sig_in[0] = ~sig_in[0];
         pb(t + 5, "sat_pul",  F_PUL, 0, 1);
         pc(t + 5, "sat_cnt",  0, 3);
         pc(t + 6, "sat_hold", 0, 3);
         step(7);
      end

      t = cyc;
      sig_in[0] = 1'b1;
      pb(t + 5, "clr_edge_pend", F_PEND, 0, 1);
      pb(t + 5, "clr_edge_pul",  F_PUL,  0, 1);
      pc(t + 5, "clr_edge_cnt",  0, 1);
      pv(t + 5, "clr_any_pre",   F_ANY, 1, 1);
      step(4);
      clr = 4'b0001;
      step(1);
      clr = 4'b0111;
      pv(t + 6, "clr_pend", F_PEND, 'hF, 0);
      pc(t + 6, "clr_cnt0", 0, 0);
      pc(t + 6, "clr_cnt1", 1, 0);
      pc(t + 6, "clr_cnt2", 2, 0);
      pv(t + 6, "clr_any",  F_ANY, 1, 0);
      pb(t + 6, "clr_lvl",  F_LVL, 0, 1);
      step(1);
      clr = '0;
      step(2);

      t = cyc;
      sig_in[0] = 1'b0;
      pb(t + 5, "pre_rst_pend", F_PEND, 0, 1);
      pc(t + 5, "pre_rst_cnt",  0, 1);
      step(7);
      sig_in[1:0] = 2'b11;
      step(3);
      #2 rst = 1'b1;
      #1;
      cmp("arst_lvl",  F_LVL,  'hF,  0);
      cmp("arst_pend", F_PEND, 'hF,  0);
      cmp("arst_cnt",  F_CNT,  'hFF, 0);
      cmp("arst_any",  F_ANY,  1,    0);
      cmp("arst_strb", F_PUL,  'hF,  0);
      step(2);
      rst = 1'b0;
      r = cyc;
      pv(r + 4, "post_early", F_LVL,  'h3, 'h0);
      pv(r + 5, "post_lvl",   F_LVL,  'h3, 'h3);
      pv(r + 5, "post_rise",  F_RISE, 'h3, 'h3);
      pv(r + 5, "post_pul",   F_PUL,  'h3, 'h3);
      pc(r + 5, "post_cnt",   0, 1);
      step(7);

      n_chk++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL sb_drain: observed %0d left expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/edge_det_multi.md
# edge_det_multi

Parametrised, multi-channel successor to the single-signal edge detector. Each of `CH` asynchronous inputs passes through a synchroniser and a stability (glitch) filter. Rising and falling edges are then detected and qualified by a per-channel mode. Qualified edges drive one-cycle pulses, sticky pending flags and saturating event counters. The block sits between raw external/cross-domain signals and the control logic that polls or reacts to edge events.

## Interface
- `CH`, 4: number of independent channels (≥1)
- `SYNC_STAGES`, 2: synchroniser flop depth (≥2)
- `FILT`, 3: consecutive synchronised cycles a new level must hold before it is accepted (≥1)
- `CNT_W`, 8: per-channel event counter width (≥1)

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `sig_in`  in  CH  raw asynchronous inputs
- `mode`  in  2*CH  per channel, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- `clr`  in  CH  per-channel synchronous clear of `pending` and `count`
- `level`  out  CH  filtered, synchronised level
- `rise`  out  CH  one-cycle raw rising-edge strobe; ignores mode
- `fall`  out  CH  one-cycle raw falling-edge strobe; ignores mode
- `pulse`  out  CH  one-cycle mode-qualified edge strobe
- `pending`  out  CH  sticky flag, set by `pulse`
- `count`  out  CH*CNT_W  channel i occupies [CNT_W*i +: CNT_W]; qualified edge count
- `any_pending`  out  1  OR of all `pending` bits

## Operation
- **Synchroniser:** a `SYNC_STAGES` shift register per channel. `sync` is its last stage.
- **Filter:** per-channel counter of width clog2(FILT+1).
  - If `sync` == `level`, the counter clears to 0.
  - Otherwise it increments. On the edge where it would reach `FILT`, `level` toggles and the counter returns to 0.
  - Any return of `sync` to `level` before then discards the run (glitch rejected).
- **Raw edge detection:** `rise`/`fall` are registered. They are set on the same edge that `level` toggles (0→1 sets `rise`, 1→0 sets `fall`) and clear on the next edge unless `level` toggles again.
- **Qualification:** a qualified edge occurs when `level` toggles and `mode` of that channel, sampled at that clock edge, permits the direction. `pulse` is registered alongside `rise`/`fall`.
- **`pending`:**
  - Set on a qualified edge.
  - Cleared by `clr`.
  - Qualified edge and `clr` in the same cycle: set wins (`pending`=1).
- **`count`:**
  - Increments on each qualified edge and saturates at 2^CNT_W−1 (no wrap).
  - `clr` alone sets it to 0.
  - `clr` together with a qualified edge sets it to 1.
- **Mode 00:** `level`, `rise` and `fall` still operate. `pulse`, `pending` and `count` stay frozen.
- **Mode changes:** take effect on the next edge decision, with no retroactive events.
- **`any_pending`:** combinational OR of the registered `pending` bits.
- **Channel independence:** channels share no state.

## Timing
- **Reset values:** all synchroniser stages, filter counters, `level`, `rise`, `fall`, `pulse`, `pending` and `count` are 0, so `any_pending`=0.
- **Reset assertion:** takes effect immediately, without waiting for a clock, including mid-filter-run or mid-pulse.
- **Input high at reset release:** because `level` resets to 0, an input already high yields a `rise` (and a `pulse` if mode permits) after the normal latency.
- **Latency:** a new `sig_in` value first sampled at edge N (and held) updates `level`, `rise`/`fall` and `pulse` at edge N+SYNC_STAGES+FILT−1. With defaults that is N+4. With FILT=1 it is N+SYNC_STAGES.
- **Minimum accepted pulse width:** FILT clock cycles at the synchroniser output. Shorter excursions produce no output change.
- **Strobe width:** `rise`/`fall`/`pulse` are high for exactly one cycle per toggle.
- **Repeat events:** two toggles cannot occur closer than FILT cycles apart, so with FILT=1 strobes may appear on consecutive cycles.
- **Clear visibility:** `clr` sampled at edge E is visible on `pending`/`count` after E; it has no effect on `level`/`rise`/`fall`.

## Test plan
- **Reset/idle:** reset with `sig_in`=0, all modes 11 → all outputs 0. Hold 20 cycles → still 0.
- **Latency and both modes:** defaults, ch0 mode 11. `sig_in[0]` 0→1 sampled at edge 10 → `level[0]`, `rise[0]`, `pulse[0]` set at edge 14, strobes clear at edge 15, `pending[0]`=1, `count[0]`=1. Drop at edge 30 → `fall[0]`/`pulse[0]` at edge 34, `count[0]`=2.
- **Glitch rejection:** FILT=3, `sig_in[1]` high for 2 cycles → no change in `level[1]`, no strobes. Then high for 3 cycles → `rise[1]` followed by `fall[1]` 3 cycles later.
- **Mode filtering:** ch2 mode 01, toggle 0→1→0 → `rise[2]` and `fall[2]` both seen, `pulse[2]` only on the rise, `count[2]`=1. Mode 00 on ch3 → `count[3]` stays 0 while `rise[3]`/`fall[3]` pulse.
- **Clear and saturation:** CNT_W=2, 5 qualified edges → `count`=3, held. `clr` on the same cycle as a qualified edge → `pending`=1, `count`=1. `clr` alone → `pending`=0, `count`=0, `any_pending` drops if no other channel is pending.
- **Async reset mid-run:** assert `rst` between clock edges during a filter run and while `pending`/`count` are nonzero → all outputs 0 immediately. After release with the input held high → `rise` appears after the nominal latency.
